// File: rtl/hdmi_dma_pkg.sv
// Shared types and helpers for the HDMI frame-capture DMA controller.
// Holds the controller state encoding, word size and a small unsigned min helper.
package hdmi_dma_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } dma_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORDS_NUMBER_W = 30;

    function automatic logic [31:0] min(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (a < b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/hdmi_dma_word_fifo.sv
// Single-clock show-ahead word FIFO with occupancy count.
// srst empties the FIFO synchronously; the head word is always visible on rdata.
module hdmi_dma_word_fifo #(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_sys,
    input  logic          rst_sys_n,
    input  logic          srst,
    input  logic          push,
    input  logic [31:0]   wdata,
    input  logic          pop,
    output logic [31:0]   rdata,
    output logic [CW-1:0] count
);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_push_s = push && (count_r != CW'(DEPTH));
    assign do_pop_s  = pop && (count_r != '0);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array write port
    always_ff @(posedge clk_sys) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_frame_dma_ctrl.sv
// Frame-capture DMA: aligns to frame_sync, buffers the frame's words and
// writes them to memory as Avalon-MM bursts starting at cfg_start_addr.
module hdmi_frame_dma_ctrl
    import hdmi_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned BURSTCOUNT_W = 5,
    parameter int unsigned FIFO_DEPTH   = 32
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys_n,
    input  logic                    cfg_enable,
    input  logic [ADDR_WIDTH-1:0]   cfg_start_addr,
    input  logic [29:0]             cfg_words_number,
    input  logic                    frame_sync,
    input  logic [31:0]             st_data,
    input  logic                    st_valid,
    output logic                    st_ready,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    output logic [BURSTCOUNT_W-1:0] avm_burstcount,
    input  logic                    avm_waitrequest,
    output logic                    sts_busy,
    output logic                    sts_frame_done,
    output logic                    sts_overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    dma_state_e              state_r;
    dma_state_e              state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_q_r;
    logic [29:0]             acc_rem_r;
    logic [29:0]             acc_rem_next_s;
    logic [29:0]             wr_rem_r;
    logic [BURSTCOUNT_W-1:0] beats_left_r;
    logic                    abort_r;
    logic                    abort_next_s;
    logic                    latch_s;
    logic                    fifo_flush_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    last_beat_s;
    logic                    launch_s;
    logic [31:0]             burst_len_s;
    logic [CW-1:0]           fifo_count_s;
    logic [CW-1:0]           fifo_count_next_s;
    logic [31:0]             fifo_rdata_s;
    logic                    st_ready_next_s;
    logic                    st_ready_r;
    logic                    avm_write_r;
    logic [ADDR_WIDTH-1:0]   avm_address_r;
    logic [BURSTCOUNT_W-1:0] avm_burstcount_r;
    logic                    sts_busy_r;
    logic                    sts_frame_done_r;
    logic                    sts_overflow_r;

    hdmi_dma_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .srst      (fifo_flush_s),
        .push      (push_s),
        .wdata     (st_data),
        .pop       (pop_s),
        .rdata     (fifo_rdata_s),
        .count     (fifo_count_s)
    );

    // st_ready_r already folds in FIFO-full, so a handshake here always has room
    assign push_s      = (state_r == CAPTURE) && !abort_r && (acc_rem_r != 30'd0)
                         && st_valid && st_ready_r;
    assign pop_s       = avm_write_r && !avm_waitrequest;
    assign last_beat_s = pop_s && (beats_left_r == BURSTCOUNT_W'(1));
    assign burst_len_s = min(32'(BURST_LEN), {2'b00, wr_rem_r});
    assign launch_s    = (state_r == CAPTURE) && !abort_r && cfg_enable && !avm_write_r
                         && (wr_rem_r != 30'd0) && (32'(fifo_count_s) >= burst_len_s);

    // Next-state decode, configuration latch and abort/flush control
    always_comb begin
        state_next_s = state_r;
        abort_next_s = 1'b0;
        latch_s      = 1'b0;
        fifo_flush_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_enable) begin
                    state_next_s = ARMED;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARMED: begin
                if (!cfg_enable) begin
                    state_next_s = IDLE;
                end else if (frame_sync) begin
                    latch_s      = 1'b1;
                    state_next_s = (cfg_words_number == 30'd0) ? DONE : CAPTURE;
                end else begin
                    state_next_s = ARMED;
                end
            end
            CAPTURE: begin
                if (abort_r || !cfg_enable) begin
                    // a burst already on the bus must finish before we flush
                    if (abort_r && !avm_write_r) begin
                        fifo_flush_s = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        abort_next_s = 1'b1;
                        state_next_s = CAPTURE;
                    end
                end else if ((wr_rem_r == 30'd0) && !avm_write_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CAPTURE;
                end
            end
            DONE: begin
                if (frame_sync && cfg_enable) begin
                    latch_s      = 1'b1;
                    state_next_s = (cfg_words_number == 30'd0) ? DONE : CAPTURE;
                end else if (cfg_enable) begin
                    state_next_s = ARMED;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Look-ahead of accept counter and FIFO level so st_ready can be registered
    always_comb begin
        acc_rem_next_s    = acc_rem_r;
        fifo_count_next_s = fifo_count_s;
        if (latch_s) begin
            acc_rem_next_s = cfg_words_number;
        end else if (push_s) begin
            acc_rem_next_s = acc_rem_r - 30'd1;
        end else begin
            acc_rem_next_s = acc_rem_r;
        end
        if (fifo_flush_s) begin
            fifo_count_next_s = '0;
        end else if (push_s && !pop_s) begin
            fifo_count_next_s = fifo_count_s + CW'(1);
        end else if (!push_s && pop_s) begin
            fifo_count_next_s = fifo_count_s - CW'(1);
        end else begin
            fifo_count_next_s = fifo_count_s;
        end
        st_ready_next_s = !((state_next_s == CAPTURE) && !abort_next_s
                            && (acc_rem_next_s != 30'd0)
                            && (fifo_count_next_s == CW'(FIFO_DEPTH)));
    end

    // State, stream-side bookkeeping and status flags
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_r          <= IDLE;
            abort_r          <= 1'b0;
            acc_rem_r        <= 30'd0;
            st_ready_r       <= 1'b0;
            sts_busy_r       <= 1'b0;
            sts_frame_done_r <= 1'b0;
            sts_overflow_r   <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            abort_r          <= abort_next_s;
            acc_rem_r        <= acc_rem_next_s;
            st_ready_r       <= st_ready_next_s;
            sts_busy_r       <= (state_next_s == CAPTURE) || (state_next_s == DONE);
            sts_frame_done_r <= (state_next_s == DONE);
            if (!cfg_enable) begin
                sts_overflow_r <= 1'b0;
            end else if ((state_r == CAPTURE) && frame_sync) begin
                sts_overflow_r <= 1'b1;
            end else begin
                sts_overflow_r <= sts_overflow_r;
            end
        end
    end

    // Burst launch, beat accounting and write address advance
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            addr_q_r         <= '0;
            wr_rem_r         <= 30'd0;
            beats_left_r     <= '0;
            avm_write_r      <= 1'b0;
            avm_address_r    <= '0;
            avm_burstcount_r <= '0;
        end else begin
            if (latch_s) begin
                addr_q_r <= cfg_start_addr;
                wr_rem_r <= cfg_words_number;
            end else if (pop_s) begin
                wr_rem_r <= wr_rem_r - 30'd1;
                if (last_beat_s) begin
                    addr_q_r <= addr_q_r + (ADDR_WIDTH'(avm_burstcount_r) * ADDR_WIDTH'(BYTES_PER_WORD));
                end
            end
            if (launch_s) begin
                avm_write_r      <= 1'b1;
                avm_address_r    <= addr_q_r;
                avm_burstcount_r <= burst_len_s[BURSTCOUNT_W-1:0];
                beats_left_r     <= burst_len_s[BURSTCOUNT_W-1:0];
            end else if (pop_s) begin
                beats_left_r <= beats_left_r - BURSTCOUNT_W'(1);
                if (last_beat_s) begin
                    avm_write_r <= 1'b0;
                end
            end
        end
    end

    assign st_ready       = st_ready_r;
    assign avm_write      = avm_write_r;
    assign avm_address    = avm_address_r;
    assign avm_burstcount = avm_burstcount_r;
    assign avm_writedata  = avm_write_r ? fifo_rdata_s : 32'h0000_0000;
    assign sts_busy       = sts_busy_r;
    assign sts_frame_done = sts_frame_done_r;
    assign sts_overflow   = sts_overflow_r;

endmodule

// File: tb/tb_hdmi_frame_dma_ctrl.sv
// Directed bench for hdmi_frame_dma_ctrl: streams frames, records Avalon bursts
// and compares against hand-computed burst lists and word images.
module tb_hdmi_frame_dma_ctrl;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        cfg_enable;
    logic [31:0] cfg_start_addr;
    logic [29:0] cfg_words_number;
    logic        frame_sync;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [4:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic        sts_busy;
    logic        sts_frame_done;
    logic        sts_overflow;

    int vec_cnt = 0;
    int err_cnt = 0;
    int stream_to_cnt = 0;
    logic rand_wr = 1'b0;

    logic [31:0] beat_data_q [$];
    logic [31:0] burst_addr_q [$];
    logic [31:0] burst_cnt_q [$];
    int beat_cnt = 0;
    int done_cnt = 0;
    int stable_err = 0;
    int beats_left_m = 0;
    logic [31:0] cur_addr = 32'h0;
    logic [4:0]  cur_bc = 5'd0;

    hdmi_frame_dma_ctrl dut (
        .clk_sys          (clk_sys),
        .rst_sys_n        (rst_sys_n),
        .cfg_enable       (cfg_enable),
        .cfg_start_addr   (cfg_start_addr),
        .cfg_words_number (cfg_words_number),
        .frame_sync       (frame_sync),
        .st_data          (st_data),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .avm_address      (avm_address),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_burstcount   (avm_burstcount),
        .avm_waitrequest  (avm_waitrequest),
        .sts_busy         (sts_busy),
        .sts_frame_done   (sts_frame_done),
        .sts_overflow     (sts_overflow)
    );

    initial forever #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave stall generator
    initial forever begin
        @(posedge clk_sys);
        #1;
        avm_waitrequest = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Avalon write monitor: records bursts, beats and done pulses
    initial forever begin
        @(negedge clk_sys);
        if (rst_sys_n === 1'b1) begin
            if (sts_frame_done) done_cnt++;
            if (avm_write) begin
                if (beats_left_m == 0) begin
                    cur_addr     = avm_address;
                    cur_bc       = avm_burstcount;
                    beats_left_m = int'(avm_burstcount);
                    burst_addr_q.push_back(avm_address);
                    burst_cnt_q.push_back(32'(avm_burstcount));
                end else if (avm_address != cur_addr || avm_burstcount != cur_bc) begin
                    stable_err++;
                end
                if (!avm_waitrequest) begin
                    beat_data_q.push_back(avm_writedata);
                    beat_cnt++;
                    beats_left_m--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_sb();
        beat_data_q.delete();
        burst_addr_q.delete();
        burst_cnt_q.delete();
        beat_cnt     = 0;
        done_cnt     = 0;
        stable_err   = 0;
        beats_left_m = 0;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        @(posedge clk_sys);
        #1;
        frame_sync = 1'b0;
    endtask

    task automatic stream_words(input int n, input logic [31:0] base);
        int guard;
        for (int i = 0; i < n; i++) begin
            st_valid = 1'b1;
            st_data  = base + 32'(i);
            guard    = 0;
            @(negedge clk_sys);
            while (!st_ready && guard < 1000) begin
                @(negedge clk_sys);
                guard++;
            end
            if (guard >= 1000) stream_to_cnt++;
            @(posedge clk_sys);
            #1;
        end
        st_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        @(negedge clk_sys);
        while (sts_busy && guard < 2000) begin
            @(negedge clk_sys);
            guard++;
        end
        chk({tag, "_idle_to"}, 64'(guard < 2000), 64'(1));
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_image(input string tag, input logic [31:0] base, input int n);
        logic [31:0] got_w;
        chk({tag, "_nbeats"}, 64'(beat_data_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            got_w = (i < beat_data_q.size()) ? beat_data_q[i] : 32'hDEAD_0000;
            chk($sformatf("%s_w%0d", tag, i), 64'(got_w), 64'(base + 32'(i)));
        end
    endtask

    task automatic check_burst(input string tag, input int idx, input logic [31:0] addr, input logic [31:0] cnt);
        logic [31:0] got_a;
        logic [31:0] got_c;
        got_a = (idx < burst_addr_q.size()) ? burst_addr_q[idx] : 32'hFFFF_FFFF;
        got_c = (idx < burst_cnt_q.size()) ? burst_cnt_q[idx] : 32'hFFFF_FFFF;
        chk({tag, "_addr"}, 64'(got_a), 64'(addr));
        chk({tag, "_bcnt"}, 64'(got_c), 64'(cnt));
    endtask

    initial begin
        int   guard;
        logic ready_ok;
        rst_sys_n        = 1'b0;
        cfg_enable       = 1'b0;
        cfg_start_addr   = 32'h0;
        cfg_words_number = 30'd0;
        frame_sync       = 1'b0;
        st_data          = 32'h0;
        st_valid         = 1'b0;
        avm_waitrequest  = 1'b0;

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_flags", 64'({st_ready, avm_write, sts_busy, sts_frame_done, sts_overflow}), 64'(0));
        chk("rst_addr", 64'(avm_address), 64'(0));
        chk("rst_bcnt", 64'(avm_burstcount), 64'(0));
        chk("rst_wdata", 64'(avm_writedata), 64'(0));
        @(posedge clk_sys);
        #1;
        rst_sys_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("idle_ready", 64'(st_ready), 64'(1));
        chk("idle_busy", 64'(sts_busy), 64'(0));
        @(posedge clk_sys);
        #1;

        // 1: 40-word frame, no stalls
        cfg_start_addr   = 32'h0000_1000;
        cfg_words_number = 30'd40;
        cfg_enable       = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        clear_sb();
        pulse_sync();
        stream_words(40, 32'hA000_0000);
        wait_idle("t1");
        check_image("t1", 32'hA000_0000, 40);
        chk("t1_nbursts", 64'(burst_addr_q.size()), 64'(3));
        check_burst("t1_b0", 0, 32'h0000_1000, 32'd16);
        check_burst("t1_b1", 1, 32'h0000_1040, 32'd16);
        check_burst("t1_b2", 2, 32'h0000_1080, 32'd8);
        chk("t1_done", 64'(done_cnt), 64'(1));
        chk("t1_stable", 64'(stable_err), 64'(0));

        // 2: same frame with random slave stalls
        rand_wr = 1'b1;
        clear_sb();
        pulse_sync();
        stream_words(40, 32'hA000_0000);
        wait_idle("t2");
        rand_wr = 1'b0;
        check_image("t2", 32'hA000_0000, 40);
        chk("t2_nbursts", 64'(burst_addr_q.size()), 64'(3));
        check_burst("t2_b0", 0, 32'h0000_1000, 32'd16);
        check_burst("t2_b1", 1, 32'h0000_1040, 32'd16);
        check_burst("t2_b2", 2, 32'h0000_1080, 32'd8);
        chk("t2_done", 64'(done_cnt), 64'(1));
        chk("t2_stable", 64'(stable_err), 64'(0));

        // 3: zero-length frame
        repeat (2) @(posedge clk_sys);
        #1;
        cfg_words_number = 30'd0;
        clear_sb();
        pulse_sync();
        @(negedge clk_sys);
        chk("t3_done_hi", 64'(sts_frame_done), 64'(1));
        @(negedge clk_sys);
        chk("t3_done_lo", 64'(sts_frame_done), 64'(0));
        @(posedge clk_sys);
        #1;
        chk("t3_writes", 64'(beat_cnt + burst_addr_q.size()), 64'(0));
        chk("t3_done_cnt", 64'(done_cnt), 64'(1));

        // 4: words before sync are dropped, short frame
        cfg_start_addr   = 32'h0000_2000;
        cfg_words_number = 30'd8;
        clear_sb();
        stream_words(100, 32'hB000_0000);
        pulse_sync();
        stream_words(8, 32'hC000_0000);
        st_valid = 1'b1;
        ready_ok = 1'b1;
        repeat (4) begin
            @(negedge clk_sys);
            ready_ok = ready_ok & st_ready;
        end
        @(posedge clk_sys);
        #1;
        st_valid = 1'b0;
        chk("t4_ready", 64'(ready_ok), 64'(1));
        wait_idle("t4");
        check_image("t4", 32'hC000_0000, 8);
        chk("t4_nbursts", 64'(burst_addr_q.size()), 64'(1));
        check_burst("t4_b0", 0, 32'h0000_2000, 32'd8);

        // 5: second frame_sync mid-capture
        cfg_start_addr   = 32'h0000_3000;
        cfg_words_number = 30'd40;
        clear_sb();
        pulse_sync();
        stream_words(10, 32'hD000_0000);
        pulse_sync();
        stream_words(30, 32'hD000_000A);
        wait_idle("t5");
        chk("t5_ovf", 64'(sts_overflow), 64'(1));
        check_image("t5", 32'hD000_0000, 40);
        chk("t5_done", 64'(done_cnt), 64'(1));
        check_burst("t5_b0", 0, 32'h0000_3000, 32'd16);
        cfg_enable = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        @(negedge clk_sys);
        chk("t5_ovf_clr", 64'(sts_overflow), 64'(0));
        @(posedge clk_sys);
        #1;

        // 6: disable during beat 5 of the first burst
        cfg_enable       = 1'b1;
        cfg_start_addr   = 32'h0000_4000;
        cfg_words_number = 30'd32;
        repeat (2) @(posedge clk_sys);
        #1;
        clear_sb();
        pulse_sync();
        stream_words(20, 32'hE000_0000);
        guard = 0;
        while (beat_cnt < 4 && guard < 200) begin
            @(posedge clk_sys);
            #1;
            guard++;
        end
        chk("t6_beat4_to", 64'(guard < 200), 64'(1));
        cfg_enable = 1'b0;
        wait_idle("t6");
        check_image("t6", 32'hE000_0000, 16);
        chk("t6_nbursts", 64'(burst_addr_q.size()), 64'(1));
        check_burst("t6_b0", 0, 32'h0000_4000, 32'd16);
        chk("t6_done", 64'(done_cnt), 64'(0));
        chk("t6_ready", 64'(st_ready), 64'(1));

        // leftover words must be gone: the next frame carries only new data
        cfg_enable       = 1'b1;
        cfg_start_addr   = 32'h0000_5000;
        cfg_words_number = 30'd4;
        repeat (2) @(posedge clk_sys);
        #1;
        clear_sb();
        pulse_sync();
        stream_words(4, 32'hF000_0000);
        wait_idle("t6b");
        check_image("t6b", 32'hF000_0000, 4);
        check_burst("t6b_b0", 0, 32'h0000_5000, 32'd4);
        chk("t6b_done", 64'(done_cnt), 64'(1));

        chk("stream_to", 64'(stream_to_cnt), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
